// File: rtl/tex_rom_arbiter.sv
// tex_rom_arbiter: round-robin share of the single-port texture BROM between
// NUM_REQ column-flattening lanes. It grants at most one texel request per cycle
// and registers the BROM address. A tag pipeline follows each accepted request
// through the fixed-latency ROM read and returns the pixel to the lane that asked
// for it.
module tex_rom_arbiter #(
   parameter int          NUM_REQ      = 4,
   parameter int          ROM_LATENCY  = 2,
   parameter int          TEX_BITS     = 6,
   parameter int          FIRST_TEX_ID = 3,
   parameter int          NUM_TEX      = 3,
   parameter logic [15:0] ERROR_PIXEL  = 16'hF81F
) (
   input  logic                         pixel_clk_in,
   input  logic                         rst_n_in,
   input  logic                         hold_in,
   input  logic [NUM_REQ-1:0]           req_valid_in,
   output logic [NUM_REQ-1:0]           req_ready_out,
   input  logic [4*NUM_REQ-1:0]         req_texture_in,
   input  logic [16*NUM_REQ-1:0]        req_wallx_in,
   input  logic [TEX_BITS*NUM_REQ-1:0]  req_tex_y_in,
   output logic [13:0]                  rom_addr_out,
   input  logic [15:0]                  rom_data_in,
   output logic [NUM_REQ-1:0]           rsp_valid_out,
   output logic [15:0]                  rsp_pixel_out,
   output logic                         busy_out
);

   localparam int LANE_W = $clog2(NUM_REQ);
   localparam int LAST   = ROM_LATENCY;

   // Texture id window, widened by one bit so the upper bound cannot wrap.
   localparam logic [4:0] TEX_LO = 5'(FIRST_TEX_ID);
   localparam logic [4:0] TEX_HI = 5'(FIRST_TEX_ID + NUM_TEX);

   // Arbitration state.
   logic [LANE_W-1:0]                 r_rr_ptr;

   // Tag pipeline: stage 0 lines up with the registered address, and stage LAST
   // lines up with valid ROM data at the input of the response register.
   logic [LAST:0]                     r_vld_pipe;
   logic [LAST:0][LANE_W-1:0]         r_lane_pipe;
   logic [LAST:0]                     r_inv_pipe;

   logic [13:0]                       r_rom_addr;
   logic [NUM_REQ-1:0]                r_rsp_valid;
   logic [15:0]                       r_rsp_pixel;

   logic                              w_arb_en;
   logic [NUM_REQ-1:0]                w_grant;
   logic [LANE_W-1:0]                 w_grant_idx;
   logic                              w_grant_any;
   logic [LANE_W:0]                   w_cand;
   logic                              w_accept;

   logic [3:0]                        w_sel_tex;
   logic [15:0]                       w_sel_wallx;
   logic [TEX_BITS-1:0]               w_sel_tex_y;
   logic [TEX_BITS-1:0]               w_tex_x;
   logic [3:0]                        w_bank;
   logic                              w_tex_ok;
   logic [13:0]                       w_addr;

   // Grants are suppressed while held or while reset is asserted.
   assign w_arb_en = rst_n_in & ~hold_in;

   // Round-robin search starting at r_rr_ptr; the first valid lane wins.
   always_comb begin
      w_grant     = '0;
      w_grant_idx = '0;
      w_grant_any = 1'b0;
      w_cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = {1'b0, r_rr_ptr} + (LANE_W+1)'(k);
         if (w_cand >= (LANE_W+1)'(NUM_REQ))
            w_cand = w_cand - (LANE_W+1)'(NUM_REQ);
         if (!w_grant_any && req_valid_in[w_cand[LANE_W-1:0]]) begin
            w_grant_any                   = 1'b1;
            w_grant_idx                   = w_cand[LANE_W-1:0];
            w_grant[w_cand[LANE_W-1:0]]   = 1'b1;
         end
      end
   end

   assign req_ready_out = w_arb_en ? w_grant : '0;
   assign w_accept      = w_arb_en & w_grant_any;

   // Fields of the granted lane.
   assign w_sel_tex   = req_texture_in[w_grant_idx*4 +: 4];
   assign w_sel_wallx = req_wallx_in[w_grant_idx*16 +: 16];
   assign w_sel_tex_y = req_tex_y_in[w_grant_idx*TEX_BITS +: TEX_BITS];

   // tex_x is the top TEX_BITS of the Q0.16 wall coordinate.
   assign w_tex_x  = w_sel_wallx[15 -: TEX_BITS];
   assign w_tex_ok = ({1'b0, w_sel_tex} >= TEX_LO) && ({1'b0, w_sel_tex} < TEX_HI);
   assign w_bank   = w_sel_tex - TEX_LO[3:0];

   // bank selects a 64x64 tile, tex_y selects a row and tex_x a column (14 bits total).
   assign w_addr = (14'(w_bank) << (2*TEX_BITS))
                 + (14'(w_sel_tex_y) << TEX_BITS)
                 + 14'(w_tex_x);

   // Round-robin pointer moves to the lane after the one just granted.
   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_rr_ptr <= '0;
      end else if (w_accept) begin
         if (w_grant_idx == LANE_W'(NUM_REQ-1))
            r_rr_ptr <= '0;
         else
            r_rr_ptr <= w_grant_idx + LANE_W'(1);
      end
   end

   // Address register; a bad texture id leaves the previous address on the ROM.
   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_rom_addr <= '0;
      end else if (w_accept && w_tex_ok) begin
         r_rom_addr <= w_addr;
      end
   end

   // Tag shift register: {valid, lane, invalid-tex} follows the ROM read latency.
   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_vld_pipe  <= '0;
         r_lane_pipe <= '0;
         r_inv_pipe  <= '0;
      end else begin
         r_vld_pipe[0]  <= w_accept;
         r_lane_pipe[0] <= w_grant_idx;
         r_inv_pipe[0]  <= ~w_tex_ok;
         for (int s = 1; s <= LAST; s++) begin
            r_vld_pipe[s]  <= r_vld_pipe[s-1];
            r_lane_pipe[s] <= r_lane_pipe[s-1];
            r_inv_pipe[s]  <= r_inv_pipe[s-1];
         end
      end
   end

   // Response register: one-hot valid for a single cycle; the pixel holds between responses.
   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_rsp_valid <= '0;
         r_rsp_pixel <= '0;
      end else begin
         r_rsp_valid <= r_vld_pipe[LAST]
                        ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << r_lane_pipe[LAST])
                        : '0;
         if (r_vld_pipe[LAST])
            r_rsp_pixel <= r_inv_pipe[LAST] ? ERROR_PIXEL : rom_data_in;
      end
   end

   assign rom_addr_out  = r_rom_addr;
   assign rsp_valid_out = r_rsp_valid;
   assign rsp_pixel_out = r_rsp_pixel;
   assign busy_out      = |r_vld_pipe;

endmodule

// File: tb/tb_tex_rom_arbiter.sv
// Directed bench for tex_rom_arbiter. The BROM model returns addr ^ 16'hA5A5 with
// a read latency of two cycles.
module tb_tex_rom_arbiter;

   logic        clk;
   logic        rst_n;
   logic        hold;
   logic [3:0]  valid;
   logic [3:0]  ready;
   logic [15:0] tex;
   logic [63:0] wx;
   logic [23:0] ty;
   logic [13:0] addr;
   logic [15:0] rom_data;
   logic [3:0]  rsp_valid;
   logic [15:0] rsp_pixel;
   logic        busy;

   logic [15:0] rom_q1, rom_q2;
   logic [13:0] exp_addr [4];

   int errors = 0;
   int checks = 0;

   tex_rom_arbiter dut (
      .pixel_clk_in   (clk),
      .rst_n_in       (rst_n),
      .hold_in        (hold),
      .req_valid_in   (valid),
      .req_ready_out  (ready),
      .req_texture_in (tex),
      .req_wallx_in   (wx),
      .req_tex_y_in   (ty),
      .rom_addr_out   (addr),
      .rom_data_in    (rom_data),
      .rsp_valid_out  (rsp_valid),
      .rsp_pixel_out  (rsp_pixel),
      .busy_out       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Two-stage BROM model.
   always @(posedge clk) begin
      rom_q1 <= {2'b00, addr} ^ 16'hA5A5;
      rom_q2 <= rom_q1;
   end
   assign rom_data = rom_q2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int i, input logic [3:0] t, input logic [15:0] w,
                           input logic [5:0] y);
      tex[i*4 +: 4] = t;
      wx[i*16 +: 16] = w;
      ty[i*6 +: 6]  = y;
   endtask

   initial begin
      rst_n = 1'b0; hold = 1'b0; valid = 4'hF; tex = '0; wx = '0; ty = '0;
      exp_addr[0] = 14'd64; exp_addr[1] = 14'd4225;
      exp_addr[2] = 14'd8386; exp_addr[3] = 14'd259;
      #3;
      chk("rst_ready", ready, 0);
      chk("rst_addr", addr, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_pixel", rsp_pixel, 0);
      chk("rst_busy", busy, 0);
      valid = 4'h0;
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Single request on lane 0: texture 3, tex_x 63, tex_y 5.
      set_lane(0, 4'd3, 16'hFC00, 6'd5);
      valid = 4'b0001;
      #1 chk("t1_ready", ready, 4'b0001);
      tick();
      valid = 4'b0000;
      chk("t1_addr", addr, 383);
      chk("t1_busy", busy, 1);
      tick(); chk("t1_rsp_e1", rsp_valid, 0);
      tick(); chk("t1_rsp_e2", rsp_valid, 0);
      tick();
      chk("t1_rsp_e3", rsp_valid, 4'b0001);
      chk("t1_pixel", rsp_pixel, 16'hA4DA);
      chk("t1_busy_done", busy, 0);
      tick();
      chk("t1_rsp_e4", rsp_valid, 0);
      chk("t1_pixel_hold", rsp_pixel, 16'hA4DA);

      // Restart from rr_ptr=0 with all four lanes streaming.
      rst_n = 1'b0; #2 rst_n = 1'b1;
      for (int i = 0; i < 4; i++)
         set_lane(i, 4'(3 + (i % 3)), 16'(i * 16'h0400), 6'(i + 1));
      for (int c = 0; c < 11; c++) begin
         valid = (c < 8) ? 4'hF : 4'h0;
         #1;
         if (c < 8) chk($sformatf("t2_ready_%0d", c), ready, 1 << (c % 4));
         tick();
         if (c < 8) chk($sformatf("t2_addr_%0d", c), addr, exp_addr[c % 4]);
         if (c >= 3) begin
            chk($sformatf("t2_rsp_%0d", c), rsp_valid, 1 << ((c - 3) % 4));
            chk($sformatf("t2_pix_%0d", c), rsp_pixel,
                {2'b00, exp_addr[(c - 3) % 4]} ^ 16'hA5A5);
         end else begin
            chk($sformatf("t2_rsp_%0d", c), rsp_valid, 0);
         end
      end

      // Lane 1 valid texture, lane 2 out-of-range texture 7.
      set_lane(1, 4'd5, 16'h0000, 6'd63);
      set_lane(2, 4'd7, 16'h8000, 6'd9);
      valid = 4'b0110;
      #1 chk("t3_ready_l1", ready, 4'b0010);
      tick();
      chk("t3_addr_l1", addr, 12224);
      valid = 4'b0100;
      #1 chk("t3_ready_l2", ready, 4'b0100);
      tick();
      chk("t3_addr_hold", addr, 12224);
      valid = 4'b0000;
      tick(); chk("t3_rsp_early", rsp_valid, 0);
      tick();
      chk("t3_rsp_l1", rsp_valid, 4'b0010);
      chk("t3_pix_l1", rsp_pixel, 16'h8A65);
      tick();
      chk("t3_rsp_l2", rsp_valid, 4'b0100);
      chk("t3_pix_l2", rsp_pixel, 16'hF81F);
      tick();
      chk("t3_rsp_idle", rsp_valid, 0);

      // Hold while two requests are in flight (rr_ptr=3 here).
      set_lane(0, 4'd3, 16'h0000, 6'd0);
      set_lane(1, 4'd4, 16'h0400, 6'd1);
      valid = 4'b0011;
      #1 chk("t4_ready_l0", ready, 4'b0001);
      tick();
      chk("t4_addr_l0", addr, 0);
      #1 chk("t4_ready_l1", ready, 4'b0010);
      tick();
      chk("t4_addr_l1", addr, 4161);
      hold = 1'b1;
      #1 chk("t4_ready_hold_a", ready, 0);
      tick();
      chk("t4_rsp_none", rsp_valid, 0);
      chk("t4_busy_a", busy, 1);
      #1 chk("t4_ready_hold_b", ready, 0);
      tick();
      chk("t4_rsp_l0", rsp_valid, 4'b0001);
      chk("t4_pix_l0", rsp_pixel, 16'hA5A5);
      chk("t4_busy_b", busy, 1);
      tick();
      chk("t4_rsp_l1", rsp_valid, 4'b0010);
      chk("t4_pix_l1", rsp_pixel, 16'hB5E4);
      chk("t4_busy_done", busy, 0);
      valid = 4'b0000; hold = 1'b0;

      // Reset with three requests in flight (rr_ptr=2 here).
      set_lane(0, 4'd3, 16'hFC00, 6'd5);
      valid = 4'hF;
      #1 chk("t5_ready_l2", ready, 4'b0100);
      tick();
      #1 chk("t5_ready_l3", ready, 4'b1000);
      tick(); tick();
      chk("t5_addr_pre", addr, 383);
      chk("t5_busy_pre", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_ready", ready, 0);
      chk("t5_rst_rsp", rsp_valid, 0);
      chk("t5_rst_pixel", rsp_pixel, 0);
      chk("t5_rst_addr", addr, 0);
      chk("t5_rst_busy", busy, 0);
      tick(); chk("t5_rst_rsp_a", rsp_valid, 0);
      tick(); chk("t5_rst_rsp_b", rsp_valid, 0);
      valid = 4'h0;
      #2 rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("t5_post_rsp_%0d", c), rsp_valid, 0);
         chk($sformatf("t5_post_busy_%0d", c), busy, 0);
      end
      valid = 4'b1001;
      #1 chk("t5_first_grant", ready, 4'b0001);
      tick();
      valid = 4'b0000;
      chk("t5_addr_after", addr, 383);
      tick(); tick(); tick();
      chk("t5_rsp_after", rsp_valid, 4'b0001);
      chk("t5_pix_after", rsp_pixel, 16'hA4DA);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
